// File: rtl/fifo_ctrl_r1024x16.sv
// Single-clock FIFO controller for a 1024x16 two-port RAM with a 2-entry prefetch buffer
// giving first-word-fall-through pop data.
module fifo_ctrl_r1024x16 #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned AFULL_LEVEL = 1000
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PushValid,
    output logic              PushReady,
    input  logic [DATA_W-1:0] PushData,
    output logic              PopValid,
    input  logic              PopReady,
    output logic [DATA_W-1:0] PopData,
    output logic [ADDR_W:0]   Count,
    output logic              AlmostFull,
    output logic              Overflow,
    output logic [ADDR_W-1:0] RamWA,
    output logic [DATA_W-1:0] RamWD,
    output logic [1:0]        RamWEN,
    output logic              RamWClkEn,
    output logic [ADDR_W-1:0] RamRA,
    output logic              RamRClkEn,
    input  logic [DATA_W-1:0] RamRD
);

    localparam logic [ADDR_W:0]   Depth      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   AfullLevel = (ADDR_W + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_W-1:0] PtrOne     = 1;
    localparam logic [ADDR_W:0]   CntOne     = 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] ra_q;
    logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;
    logic [1:0]        buf_left;
    logic              overflow_q, overflow_d;
    logic              push_fire, pop_now, issue;
    logic [2:0]        occ_after;

    assign PushReady = (ram_cnt_q < Depth);
    assign PopValid  = (buf_cnt_q != 2'd0);
    assign PopData   = buf0_q;
    assign Count     = count_q;
    assign AlmostFull = (count_q >= AfullLevel);
    assign Overflow  = overflow_q;

    assign push_fire = PushValid && PushReady;
    assign pop_now   = PopValid && PopReady;

    // Only prefetch when the buffer plus the word in flight leaves room after this pop.
    assign occ_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop_now};
    assign issue     = (ram_cnt_q != '0) && (occ_after < 3'd2);

    assign RamWA     = wr_ptr_q;
    assign RamWD     = PushData;
    assign RamWEN    = push_fire ? 2'b11 : 2'b00;
    assign RamWClkEn = push_fire;
    assign RamRA     = issue ? rd_ptr_q : ra_q;
    assign RamRClkEn = issue;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ram_cnt_d  = ram_cnt_q;
        inflight_d = issue;
        overflow_d = overflow_q | (PushValid & ~PushReady);

        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        if (push_fire && !issue) begin
            ram_cnt_d = ram_cnt_q + CntOne;
        end else if (issue && !push_fire) begin
            ram_cnt_d = ram_cnt_q - CntOne;
        end
    end

    // Shift out on pop first, then append the returning RAM word behind what is left.
    always_comb begin
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        buf_left  = buf_cnt_q - {1'b0, pop_now};
        buf_cnt_d = buf_left + {1'b0, inflight_q};

        if (pop_now) begin
            buf0_d = buf1_q;
        end
        if (inflight_q) begin
            if (buf_left == 2'd0) begin
                buf0_d = RamRD;
            end else begin
                buf1_d = RamRD;
            end
        end
    end

    assign count_d = ram_cnt_d + (ADDR_W + 1)'(inflight_d) + (ADDR_W + 1)'(buf_cnt_d);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ra_q       <= '0;
            ram_cnt_q  <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            buf_cnt_q  <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ra_q       <= RamRA;
            ram_cnt_q  <= ram_cnt_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            buf_cnt_q  <= buf_cnt_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_r1024x16.sv
// Bench for fifo_ctrl_r1024x16: behavioural RAM, pop-data scoreboard and per-scenario tasks.
module tb_fifo_ctrl_r1024x16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        PushValid;
    logic        PushReady;
    logic [15:0] PushData;
    logic        PopValid;
    logic        PopReady;
    logic [15:0] PopData;
    logic [10:0] Count;
    logic        AlmostFull;
    logic        Overflow;
    logic [9:0]  RamWA;
    logic [15:0] RamWD;
    logic [1:0]  RamWEN;
    logic        RamWClkEn;
    logic [9:0]  RamRA;
    logic        RamRClkEn;
    logic [15:0] RamRD;

    int n_checks = 0;
    int n_pass = 0;
    int n_pops = 0;
    int n_wr_wraps = 0;
    int n_rd_wraps = 0;

    logic [15:0] exp_q[$];
    logic [9:0]  exp_wa = '0;
    logic [9:0]  exp_ra = '0;
    logic [15:0] mem [0:1023];

    fifo_ctrl_r1024x16 dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .PushValid  (PushValid),
        .PushReady  (PushReady),
        .PushData   (PushData),
        .PopValid   (PopValid),
        .PopReady   (PopReady),
        .PopData    (PopData),
        .Count      (Count),
        .AlmostFull (AlmostFull),
        .Overflow   (Overflow),
        .RamWA      (RamWA),
        .RamWD      (RamWD),
        .RamWEN     (RamWEN),
        .RamWClkEn  (RamWClkEn),
        .RamRA      (RamRA),
        .RamRClkEn  (RamRClkEn),
        .RamRD      (RamRD)
    );

    always #5 Clk = ~Clk;

    // RAM with unregistered read path: data valid the cycle after the read enable.
    always @(posedge Clk) begin
        if (RamWClkEn && RamWEN == 2'b11) mem[RamWA] <= RamWD;
        if (RamRClkEn) RamRD <= mem[RamRA];
    end

    // Scoreboard: record accepted pushes, compare every accepted pop against the queue head.
    always @(negedge Clk) begin
        if (Rst) begin
            exp_q.delete();
            exp_wa = '0;
            exp_ra = '0;
        end else begin
            n_checks++;
            if (PushValid && PushReady) begin
                if (RamWClkEn !== 1'b1 || RamWEN !== 2'b11 || RamWA !== exp_wa
                    || RamWD !== PushData) begin
                    $display("FAIL ram_write: got en=%0b wen=%0b wa=%0d wd=%0h, expected 1 11 %0d %0h",
                             RamWClkEn, RamWEN, RamWA, RamWD, exp_wa, PushData);
                end else begin
                    n_pass++;
                end
                exp_q.push_back(PushData);
                if (exp_wa == 10'd1023) n_wr_wraps++;
                exp_wa = exp_wa + 10'd1;
            end else begin
                if (RamWClkEn !== 1'b0 || RamWEN !== 2'b00) begin
                    $display("FAIL ram_no_write: got en=%0b wen=%0b, expected 0 00",
                             RamWClkEn, RamWEN);
                end else begin
                    n_pass++;
                end
            end
            if (RamRClkEn === 1'b1) begin
                n_checks++;
                if (RamRA !== exp_ra || (RamWClkEn && RamWA == RamRA)) begin
                    $display("FAIL ram_read: got ra=%0d (wa=%0d wen=%0b), expected ra=%0d no collision",
                             RamRA, RamWA, RamWClkEn, exp_ra);
                end else begin
                    n_pass++;
                end
                if (exp_ra == 10'd1023) n_rd_wraps++;
                exp_ra = exp_ra + 10'd1;
            end
            if (PopValid && PopReady) begin
                n_checks++;
                n_pops++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_data: got %0h, expected no pop (scoreboard empty)", PopData);
                end else begin
                    if (PopData !== exp_q[0]) begin
                        $display("FAIL pop_data: got %0h, expected %0h", PopData, exp_q[0]);
                    end else begin
                        n_pass++;
                    end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pops until empty or budget spent; ok reports whether it emptied.
    task automatic drain(input int budget, output bit ok);
        PushValid = 1'b0;
        PopReady  = 1'b1;
        for (int i = 0; i < budget && Count != 0; i++) tick();
        tick();
        PopReady = 1'b0;
        ok = (Count == 0) && (PopValid == 1'b0) && (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        PushValid = 1'b0;
        PopReady = 1'b0;
        PushData = '0;
        repeat (3) tick();
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({PushReady, PopValid, Count, AlmostFull, Overflow} !== {1'b1, 1'b0, 11'd0, 1'b0, 1'b0})
            $display("FAIL reset_status: got pr=%0b pv=%0b cnt=%0d af=%0b ov=%0b, expected 1 0 0 0 0",
                     PushReady, PopValid, Count, AlmostFull, Overflow);
        else n_pass++;
        n_checks++;
        if ({RamWEN, RamWClkEn, RamRClkEn} !== 4'b0000)
            $display("FAIL reset_ram: got wen=%0b wce=%0b rce=%0b, expected 00 0 0",
                     RamWEN, RamWClkEn, RamRClkEn);
        else n_pass++;
        tick();
    endtask

    task automatic test_push4();
        bit ok;
        PopReady = 1'b0;
        PushValid = 1'b1;
        PushData = 16'h0001;
        #1;
        n_checks++;
        if (RamWA !== 10'd0 || RamWClkEn !== 1'b1)
            $display("FAIL push4_first_wa: got wa=%0d en=%0b, expected 0 1", RamWA, RamWClkEn);
        else n_pass++;
        tick();
        PushData = 16'h0002;
        n_checks++;
        if (PopValid !== 1'b0) $display("FAIL push4_pv_n0: got %0b, expected 0", PopValid);
        else n_pass++;
        tick();
        PushData = 16'h0003;
        n_checks++;
        if (PopValid !== 1'b0) $display("FAIL push4_pv_n1: got %0b, expected 0", PopValid);
        else n_pass++;
        tick();
        PushData = 16'h0004;
        n_checks++;
        if (PopValid !== 1'b1 || PopData !== 16'h0001)
            $display("FAIL push4_pv_n2: got pv=%0b data=%0h, expected 1 0001", PopValid, PopData);
        else n_pass++;
        tick();
        PushValid = 1'b0;
        n_checks++;
        if (Count !== 11'd4) $display("FAIL push4_count: got %0d, expected 4", Count);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if (Count !== 11'd4 || PopValid !== 1'b1 || PopData !== 16'h0001)
            $display("FAIL push4_hold: got cnt=%0d pv=%0b data=%0h, expected 4 1 0001",
                     Count, PopValid, PopData);
        else n_pass++;
        drain(50, ok);
        n_checks++;
        if (!ok) $display("FAIL push4_drain: got cnt=%0d, expected 0", Count);
        else n_pass++;
    endtask

    task automatic test_pass_through();
        bit ok;
        int pops0 = n_pops;
        PopReady = 1'b1;
        PushValid = 1'b1;
        PushData = 16'hA5A5;
        tick();
        PushData = 16'h5A5A;
        tick();
        PushValid = 1'b0;
        drain(50, ok);
        n_checks++;
        if (!ok || n_pops - pops0 != 2)
            $display("FAIL pass_through: got cnt=%0d pops=%0d, expected 0 2", Count, n_pops - pops0);
        else n_pass++;
    endtask

    task automatic test_fill();
        bit ok;
        int sent = 0;
        int af_at = -1;
        int pops0;
        PopReady = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            if (AlmostFull && af_at < 0) af_at = int'(Count);
            if (!PushReady) break;
            PushValid = 1'b1;
            PushData = 16'h1000 + 16'(sent);
            sent++;
            tick();
        end
        PushValid = 1'b0;
        n_checks++;
        if (PushReady !== 1'b0 || Count !== 11'd1026 || sent != 1026)
            $display("FAIL fill_full: got pr=%0b cnt=%0d sent=%0d, expected 0 1026 1026",
                     PushReady, Count, sent);
        else n_pass++;
        n_checks++;
        if (af_at != 1000 || AlmostFull !== 1'b1)
            $display("FAIL fill_afull: got first_count=%0d af=%0b, expected 1000 1", af_at, AlmostFull);
        else n_pass++;
        n_checks++;
        if (Overflow !== 1'b0) $display("FAIL fill_no_ovf: got %0b, expected 0", Overflow);
        else n_pass++;
        PushValid = 1'b1;
        PushData = 16'hDEAD;
        tick();
        PushValid = 1'b0;
        n_checks++;
        if (Overflow !== 1'b1 || Count !== 11'd1026)
            $display("FAIL fill_ovf: got ov=%0b cnt=%0d, expected 1 1026", Overflow, Count);
        else n_pass++;
        pops0 = n_pops;
        PopReady = 1'b1;
        #3;
        n_checks++;
        if (PushReady !== 1'b0 || RamRClkEn !== 1'b1)
            $display("FAIL fill_ready_comb: got pr=%0b rce=%0b, expected 0 1", PushReady, RamRClkEn);
        else n_pass++;
        @(posedge Clk);
        #1;
        n_checks++;
        if (PushReady !== 1'b1) $display("FAIL fill_ready_next: got %0b, expected 1", PushReady);
        else n_pass++;
        drain(1200, ok);
        n_checks++;
        if (!ok || n_pops - pops0 != 1026 || Overflow !== 1'b1)
            $display("FAIL fill_drain: got cnt=%0d pops=%0d ov=%0b, expected 0 1026 1",
                     Count, n_pops - pops0, Overflow);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int sent = 0;
        int pops0 = n_pops;
        int ww0 = n_wr_wraps;
        int rw0 = n_rd_wraps;
        for (int i = 0; i < 20000 && sent < 3000; i++) begin
            PopReady = 1'($urandom_range(0, 1));
            PushValid = 1'b1;
            PushData = 16'(sent);
            @(negedge Clk);
            if (PushValid && PushReady) sent++;
            tick();
        end
        PushValid = 1'b0;
        drain(2000, ok);
        n_checks++;
        if (!ok || sent != 3000 || n_pops - pops0 != 3000)
            $display("FAIL wrap_stream: got sent=%0d pops=%0d cnt=%0d, expected 3000 3000 0",
                     sent, n_pops - pops0, Count);
        else n_pass++;
        n_checks++;
        if (n_wr_wraps - ww0 < 2 || n_rd_wraps - rw0 < 2)
            $display("FAIL wrap_ptrs: got wr_wraps=%0d rd_wraps=%0d, expected >=2 each",
                     n_wr_wraps - ww0, n_rd_wraps - rw0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int pops0 = n_pops;
        int bad = 0;
        PopReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            PushValid = 1'b1;
            PushData = 16'h7000 + 16'(i);
            tick();
        end
        PushValid = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (Count !== 11'd5) $display("FAIL b2b_prefill: got %0d, expected 5", Count);
        else n_pass++;
        PopReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            PushValid = 1'b1;
            PushData = 16'h7100 + 16'(i);
            tick();
            n_checks++;
            if (Count !== 11'd5) $display("FAIL b2b_count: got %0d, expected 5 (cycle %0d)", Count, i);
            else n_pass++;
        end
        PushValid = 1'b0;
        drain(50, ok);
        n_checks++;
        if (!ok || n_pops - pops0 != 105)
            $display("FAIL b2b_drain: got pops=%0d cnt=%0d, expected 105 0", n_pops - pops0, Count);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pops0;
        PopReady = 1'b0;
        for (int i = 0; i < 11; i++) begin
            PushValid = 1'b1;
            PushData = 16'h9000 + 16'(i);
            tick();
        end
        PushValid = 1'b0;
        repeat (4) tick();
        PopReady = 1'b1;
        tick();
        PopReady = 1'b0;
        n_checks++;
        if (Count !== 11'd10) $display("FAIL rstmid_pre: got %0d, expected 10", Count);
        else n_pass++;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        #1;
        n_checks++;
        if ({Count, PopValid, PushReady, Overflow} !== {11'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL rstmid_clear: got cnt=%0d pv=%0b pr=%0b ov=%0b, expected 0 0 1 0",
                     Count, PopValid, PushReady, Overflow);
        else n_pass++;
        tick();
        n_checks++;
        if (Count !== 11'd0 || PopValid !== 1'b0)
            $display("FAIL rstmid_stale: got cnt=%0d pv=%0b, expected 0 0", Count, PopValid);
        else n_pass++;
        pops0 = n_pops;
        for (int i = 0; i < 3; i++) begin
            PushValid = 1'b1;
            PushData = 16'hB001 + 16'(i);
            tick();
        end
        PushValid = 1'b0;
        drain(50, ok);
        n_checks++;
        if (!ok || n_pops - pops0 != 3)
            $display("FAIL rstmid_after: got pops=%0d cnt=%0d, expected 3 0", n_pops - pops0, Count);
        else n_pass++;
    endtask

    initial begin
        Rst = 1'b1;
        PushValid = 1'b0;
        PopReady = 1'b0;
        PushData = '0;
        RamRD = '0;
        test_reset();
        test_push4();
        test_pass_through();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
